// File: rtl/rc4_ksa_shuffle.sv
// -----------------------------------------------------------------------------
// rc4_ksa_shuffle
//
// RC4 key-scheduling shuffle engine. It works on an external single-port
// synchronous S-RAM that already holds S[k] = k. For i = 0..DEPTH-1 it computes
// j = j + S[i] + key[i mod KEY_BYTES] and swaps S[i] and S[j]. Each iteration
// reads S[i], reads S[j], writes S[i], then writes S[j]. When the iteration
// with i = DEPTH-1 finishes, a one-cycle done pulse is raised.
//
// Parameters
//   ADDR_W     S-RAM address width. This is also the S element width and the
//              key element width. DEPTH = 2**ADDR_W.
//   KEY_BYTES  number of key elements (>= 1). Need not be a power of two.
//   RD_LAT     RAM read latency in cycles (>= 1).
//
// Ports
//   clk         clock; all state changes on the rising edge
//   reset       synchronous, active-high
//   start       begin a shuffle; only sampled while idle
//   secret_key  key; element 0 is the most-significant ADDR_W bits
//   data_in     RAM read data, valid RD_LAT cycles after the address
//   address     RAM address
//   data_out    RAM write data; zero unless a write is in progress
//   wren        RAM write enable
//   busy        high in every state except IDLE
//   done        one-cycle completion pulse
//
// All outputs are decoded from registered state only. No input reaches an
// output combinationally.
// -----------------------------------------------------------------------------
module rc4_ksa_shuffle #(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3,
  parameter int RD_LAT    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_W*KEY_BYTES-1:0] secret_key,
  input  logic [ADDR_W-1:0]           data_in,
  output logic [ADDR_W-1:0]           address,
  output logic [ADDR_W-1:0]           data_out,
  output logic                        wren,
  output logic                        busy,
  output logic                        done
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_RD_I = 4'd1;
  localparam logic [3:0] S_WT_I = 4'd2;
  localparam logic [3:0] S_LD_I = 4'd3;
  localparam logic [3:0] S_RD_J = 4'd4;
  localparam logic [3:0] S_WT_J = 4'd5;
  localparam logic [3:0] S_LD_J = 4'd6;
  localparam logic [3:0] S_WR_I = 4'd7;
  localparam logic [3:0] S_WR_J = 4'd8;
  localparam logic [3:0] S_DONE = 4'd9;

  localparam int KEY_W  = ADDR_W * KEY_BYTES;
  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int WT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [ADDR_W-1:0] I_LAST  = {ADDR_W{1'b1}};
  localparam logic [KIDX_W-1:0] K_LAST  = KIDX_W'(KEY_BYTES - 1);
  // The wait states stretch the read by RD_LAT-1 cycles. The counter
  // therefore runs from 0 to RD_LAT-2.
  localparam logic [WT_W-1:0]   WT_LAST = WT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  logic [3:0]        state_reg,  state_next;
  logic [ADDR_W-1:0] i_reg,      i_next;
  logic [ADDR_W-1:0] j_reg,      j_next;
  logic [ADDR_W-1:0] si_reg,     si_next;
  logic [ADDR_W-1:0] sj_reg,     sj_next;
  logic [KEY_W-1:0]  key_q_reg,  key_q_next;
  logic [KIDX_W-1:0] kidx_reg,   kidx_next;
  logic [WT_W-1:0]   wt_cnt_reg, wt_cnt_next;

  logic [ADDR_W-1:0] key_arr [KEY_BYTES];
  logic [ADDR_W-1:0] key_sel;
  logic [ADDR_W-1:0] j_sum;

  // Split the latched key into elements. Element 0 is the top slice.
  genvar gi;
  generate
    for (gi = 0; gi < KEY_BYTES; gi++) begin : g_key
      assign key_arr[gi] = key_q_reg[(KEY_BYTES-1-gi)*ADDR_W +: ADDR_W];
    end
    if (KEY_BYTES == 1) begin : g_key_one
      assign key_sel = key_arr[0];
    end else begin : g_key_many
      // kidx_reg is a mod-KEY_BYTES counter that steps with i. It never
      // indexes past the last element.
      assign key_sel = key_arr[kidx_reg];
    end
  endgenerate

  // Truncating to ADDR_W bits gives the mod-DEPTH wrap for free.
  assign j_sum = j_reg + data_in + key_sel;

  always_comb begin
    state_next  = state_reg;
    i_next      = i_reg;
    j_next      = j_reg;
    si_next     = si_reg;
    sj_next     = sj_reg;
    key_q_next  = key_q_reg;
    kidx_next   = kidx_reg;
    wt_cnt_next = wt_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          key_q_next = secret_key;
          i_next     = '0;
          j_next     = '0;
          kidx_next  = '0;
          state_next = S_RD_I;
        end
      end
      S_RD_I: begin
        wt_cnt_next = '0;
        state_next  = (RD_LAT > 1) ? S_WT_I : S_LD_I;
      end
      S_WT_I: begin
        if (wt_cnt_reg == WT_LAST) state_next = S_LD_I;
        else                       wt_cnt_next = wt_cnt_reg + WT_W'(1);
      end
      S_LD_I: begin
        si_next    = data_in;
        j_next     = j_sum;
        state_next = S_RD_J;
      end
      S_RD_J: begin
        wt_cnt_next = '0;
        state_next  = (RD_LAT > 1) ? S_WT_J : S_LD_J;
      end
      S_WT_J: begin
        if (wt_cnt_reg == WT_LAST) state_next = S_LD_J;
        else                       wt_cnt_next = wt_cnt_reg + WT_W'(1);
      end
      S_LD_J: begin
        sj_next    = data_in;
        state_next = S_WR_I;
      end
      S_WR_I: begin
        state_next = S_WR_J;
      end
      S_WR_J: begin
        // Termination uses the explicit last-index check. i never has to
        // wrap back to zero on its own.
        if (i_reg == I_LAST) begin
          state_next = S_DONE;
        end else begin
          i_next     = i_reg + ADDR_W'(1);
          kidx_next  = (kidx_reg == K_LAST) ? '0 : kidx_reg + KIDX_W'(1);
          state_next = S_RD_I;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      i_reg      <= '0;
      j_reg      <= '0;
      si_reg     <= '0;
      sj_reg     <= '0;
      key_q_reg  <= '0;
      kidx_reg   <= '0;
      wt_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      i_reg      <= i_next;
      j_reg      <= j_next;
      si_reg     <= si_next;
      sj_reg     <= sj_next;
      key_q_reg  <= key_q_next;
      kidx_reg   <= kidx_next;
      wt_cnt_reg <= wt_cnt_next;
    end
  end

  // Moore output decode. When i == j, the two writes hit the same address
  // with equal data, so no special case is needed.
  always_comb begin
    address  = '0;
    data_out = '0;
    wren     = 1'b0;
    case (state_reg)
      S_RD_I, S_WT_I: address = i_reg;
      S_RD_J, S_WT_J: address = j_reg;
      S_WR_I: begin
        address  = i_reg;
        data_out = sj_reg;
        wren     = 1'b1;
      end
      S_WR_J: begin
        address  = j_reg;
        data_out = si_reg;
        wren     = 1'b1;
      end
      default: begin
        address  = '0;
        data_out = '0;
        wren     = 1'b0;
      end
    endcase
  end

  assign busy = (state_reg != S_IDLE);
  assign done = (state_reg == S_DONE);

endmodule

// File: tb/tb_rc4_ksa_shuffle.sv
// -----------------------------------------------------------------------------
// tb_rc4_ksa_shuffle
//
// Four engine instances, each attached to its own RAM model:
//   0: ADDR_W=2, KEY_BYTES=1, RD_LAT=1
//   1: ADDR_W=2, KEY_BYTES=2, RD_LAT=1
//   2: ADDR_W=8, KEY_BYTES=3, RD_LAT=1
//   3: ADDR_W=8, KEY_BYTES=3, RD_LAT=2
// Expected images come from hand-derived constants or from a software RC4 KSA
// model. They are queued when a run starts and popped when done appears.
// -----------------------------------------------------------------------------
module tb_rc4_ksa_shuffle;

  localparam int NI = 4;

  typedef logic [255:0][7:0] img_t;

  typedef struct packed {
    logic [7:0]  n;
    logic [31:0] exp_done;
    img_t        img;
  } exp_t;

  typedef struct {
    int          n;
    logic [23:0] key;
    int          exp_done;
    bit          use_model;
    img_t        img;
    string       tag;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset;
  logic        start_v [NI];
  logic [23:0] key_v   [NI];
  logic [7:0]  din_v   [NI];
  logic [7:0]  addr_v  [NI];
  logic [7:0]  dout_v  [NI];
  logic        wren_v  [NI];
  logic        busy_v  [NI];
  logic        done_v  [NI];

  logic [1:0] s0_addr, s0_dout, s1_addr, s1_dout;

  rc4_ksa_shuffle #(.ADDR_W(2), .KEY_BYTES(1), .RD_LAT(1)) u_s0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .secret_key(key_v[0][1:0]),
    .data_in(din_v[0][1:0]), .address(s0_addr), .data_out(s0_dout),
    .wren(wren_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  rc4_ksa_shuffle #(.ADDR_W(2), .KEY_BYTES(2), .RD_LAT(1)) u_s1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .secret_key(key_v[1][3:0]),
    .data_in(din_v[1][1:0]), .address(s1_addr), .data_out(s1_dout),
    .wren(wren_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  rc4_ksa_shuffle #(.ADDR_W(8), .KEY_BYTES(3), .RD_LAT(1)) u_b1 (
    .clk(clk), .reset(reset), .start(start_v[2]), .secret_key(key_v[2]),
    .data_in(din_v[2]), .address(addr_v[2]), .data_out(dout_v[2]),
    .wren(wren_v[2]), .busy(busy_v[2]), .done(done_v[2])
  );

  rc4_ksa_shuffle #(.ADDR_W(8), .KEY_BYTES(3), .RD_LAT(2)) u_b2 (
    .clk(clk), .reset(reset), .start(start_v[3]), .secret_key(key_v[3]),
    .data_in(din_v[3]), .address(addr_v[3]), .data_out(dout_v[3]),
    .wren(wren_v[3]), .busy(busy_v[3]), .done(done_v[3])
  );

  assign addr_v[0] = {6'b0, s0_addr};
  assign dout_v[0] = {6'b0, s0_dout};
  assign addr_v[1] = {6'b0, s1_addr};
  assign dout_v[1] = {6'b0, s1_dout};

  function automatic int aw(input int n);
    return (n < 2) ? 2 : 8;
  endfunction
  function automatic int kb(input int n);
    return (n == 0) ? 1 : ((n == 1) ? 2 : 3);
  endfunction
  function automatic int lat(input int n);
    return (n == 3) ? 2 : 1;
  endfunction

  // RAM models: single port, synchronous, with RD_LAT-stage read pipelines.
  logic [7:0] mem [NI][256];
  logic [7:0] p1 [NI];
  logic [7:0] p2 [NI];
  logic       init_req [NI] = '{default: 1'b0};

  always @(posedge clk) begin
    for (int n = 0; n < NI; n++) begin
      if (init_req[n]) begin
        for (int k = 0; k < 256; k++) mem[n][k] <= 8'(k);
      end else if (wren_v[n]) begin
        mem[n][addr_v[n]] <= dout_v[n];
      end
      p1[n] <= mem[n][addr_v[n]];
      p2[n] <= p1[n];
    end
  end

  always_comb begin
    for (int n = 0; n < NI; n++) din_v[n] = (lat(n) == 1) ? p1[n] : p2[n];
  end

  // Passive monitor. It counts writes and done pulses, and counts protocol
  // violations.
  int wr_cnt   [NI] = '{default: 0};
  int done_cnt [NI] = '{default: 0};
  int viol     [NI] = '{default: 0};

  always @(negedge clk) begin
    for (int n = 0; n < NI; n++) begin
      if (wren_v[n] === 1'b1) wr_cnt[n] <= wr_cnt[n] + 1;
      if (done_v[n] === 1'b1) done_cnt[n] <= done_cnt[n] + 1;
      if ((wren_v[n] === 1'b0 && dout_v[n] !== 8'd0) ||
          (wren_v[n] === 1'b1 && busy_v[n] !== 1'b1) ||
          (done_v[n] === 1'b1 && (wren_v[n] !== 1'b0 || busy_v[n] !== 1'b1)))
        viol[n] <= viol[n] + 1;
    end
  end

  // Software RC4 KSA reference.
  function automatic img_t ksa_model(input img_t s_in, input int n, input logic [23:0] key);
    img_t       s;
    int         depth, mask, j, kel, sh;
    logic [7:0] t;
    s     = s_in;
    depth = 1 << aw(n);
    mask  = depth - 1;
    j     = 0;
    for (int i = 0; i < depth; i++) begin
      sh  = (kb(n) - 1 - (i % kb(n))) * aw(n);
      kel = int'(key >> sh) & mask;
      j   = (j + int'(s[i]) + kel) & mask;
      t    = s[i];
      s[i] = s[j];
      s[j] = t;
    end
    return s;
  endfunction

  function automatic img_t ident(input int n);
    img_t s;
    s = '0;
    for (int k = 0; k < (1 << aw(n)); k++) s[k] = 8'(k);
    return s;
  endfunction

  int   checks = 0;
  int   errors = 0;
  int   start_cyc = 0;
  exp_t sb_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic init_ram(input int n);
    @(negedge clk);
    init_req[n] = 1'b1;
    @(negedge clk);
    init_req[n] = 1'b0;
  endtask

  task automatic push_exp(input int n, input int exp_done, input img_t img);
    exp_t e;
    e.n        = 8'(n);
    e.exp_done = 32'(exp_done);
    e.img      = img;
    sb_q.push_back(e);
  endtask

  // Start is presented on a falling edge and sampled by the next rising
  // edge. Cycle k of the run sees cyc == start_cyc + k - 1.
  task automatic kick(input int n, input logic [23:0] key, input bit hold);
    @(negedge clk);
    key_v[n]   = key;
    start_v[n] = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    if (!hold) start_v[n] = 1'b0;
  endtask

  // Wait (bounded) for done, then pop the scoreboard and compare.
  // mode 1: pulse start at run cycle 10; mode 2: change the key at cycle 10.
  task automatic score(input int n, input string tag, input int w0, input int mode);
    exp_t e;
    bit   got;
    int   k, diffs, depth, rel;
    got   = 1'b0;
    k     = 0;
    diffs = 0;
    depth = 1 << aw(n);
    for (int c = 0; c < 5000 && !got; c++) begin
      @(negedge clk);
      rel = cyc - start_cyc + 1;
      if (mode == 1 && rel == 10) start_v[n] = 1'b1;
      if (mode == 1 && rel == 11) start_v[n] = 1'b0;
      if (mode == 2 && rel == 10) key_v[n] = ~key_v[n];
      if (done_v[n] === 1'b1) begin
        got = 1'b1;
        k   = rel;
      end
    end
    e = sb_q.pop_front();
    check({tag, " done_seen"}, 32'(got), 32'd1);
    check({tag, " done_cycle"}, k, e.exp_done);
    for (int a = 0; a < depth; a++) if (mem[n][a] !== e.img[a]) diffs++;
    check({tag, " ram_image_diffs"}, diffs, 0);
    check({tag, " write_count"}, wr_cnt[n] - w0, 2 * depth);
  endtask

  task automatic post(input int n, input string tag, input int d0, input int pulses);
    repeat (4) @(negedge clk);
    check({tag, " done_pulses"}, done_cnt[n] - d0, pulses);
    check({tag, " idle_busy"}, 32'(busy_v[n]), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  vec_t vecs [4];
  img_t img, img1, img_c;
  int   n, w0, d0;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0;
      key_v[i]   = '0;
    end
    repeat (3) @(negedge clk);

    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst%0d busy", i), 32'(busy_v[i]), 0);
      check($sformatf("rst%0d done", i), 32'(done_v[i]), 0);
      check($sformatf("rst%0d wren", i), 32'(wren_v[i]), 0);
      check($sformatf("rst%0d address", i), 32'(addr_v[i]), 0);
      check($sformatf("rst%0d data_out", i), 32'(dout_v[i]), 0);
    end
    reset = 1'b0;

    // Table of plain runs. The two small images are derived by hand.
    img = '0;
    img[0] = 8'd0; img[1] = 8'd2; img[2] = 8'd3; img[3] = 8'd1;
    vecs[0] = '{n: 0, key: 24'h0, exp_done: 25, use_model: 1'b0, img: img, tag: "t1_key0"};
    img = '0;
    img[0] = 8'd0; img[1] = 8'd3; img[2] = 8'd2; img[3] = 8'd1;
    vecs[1] = '{n: 1, key: 24'h6, exp_done: 25, use_model: 1'b0, img: img, tag: "t2_key12"};
    vecs[2] = '{n: 2, key: 24'hA53CF1, exp_done: 1537, use_model: 1'b1, img: '0, tag: "t3_lat1"};
    vecs[3] = '{n: 3, key: 24'hA53CF1, exp_done: 2049, use_model: 1'b1, img: '0, tag: "t3_lat2"};

    for (int v = 0; v < 4; v++) begin
      n = vecs[v].n;
      init_ram(n);
      img = vecs[v].use_model ? ksa_model(ident(n), n, vecs[v].key) : vecs[v].img;
      push_exp(n, vecs[v].exp_done, img);
      w0 = wr_cnt[n];
      d0 = done_cnt[n];
      kick(n, vecs[v].key, 1'b0);
      score(n, vecs[v].tag, w0, 0);
      post(n, vecs[v].tag, d0, 1);
    end

    // Start re-pulsed mid-run must be ignored.
    init_ram(2);
    push_exp(2, 1537, ksa_model(ident(2), 2, 24'h13579B));
    w0 = wr_cnt[2];
    d0 = done_cnt[2];
    kick(2, 24'h13579B, 1'b0);
    score(2, "t5_restart", w0, 1);
    post(2, "t5_restart", d0, 1);

    // A key change mid-run must not affect the result.
    init_ram(3);
    push_exp(3, 2049, ksa_model(ident(3), 3, 24'h2468AC));
    w0 = wr_cnt[3];
    d0 = done_cnt[3];
    kick(3, 24'h2468AC, 1'b0);
    score(3, "t6_keychg", w0, 2);
    post(3, "t6_keychg", d0, 1);

    // Reset asserted at cycle 100 of a run, then a fresh run on the
    // corrupted image.
    init_ram(2);
    kick(2, 24'hC0FFEE, 1'b0);
    for (int c = 0; c < 200 && (cyc - start_cyc + 1) < 100; c++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t4 busy_after_reset", 32'(busy_v[2]), 0);
    check("t4 wren_after_reset", 32'(wren_v[2]), 0);
    check("t4 done_after_reset", 32'(done_v[2]), 0);
    check("t4 address_after_reset", 32'(addr_v[2]), 0);
    for (int a = 0; a < 256; a++) img_c[a] = mem[2][a];
    push_exp(2, 1537, ksa_model(img_c, 2, 24'h0BADF0));
    w0 = wr_cnt[2];
    d0 = done_cnt[2];
    kick(2, 24'h0BADF0, 1'b0);
    score(2, "t4_after_reset", w0, 0);
    post(2, "t4_after_reset", d0, 1);

    // Start held high across DONE: one IDLE cycle, then a second run.
    init_ram(1);
    img1 = ksa_model(ident(1), 1, 24'h9);
    push_exp(1, 25, img1);
    w0 = wr_cnt[1];
    d0 = done_cnt[1];
    kick(1, 24'h9, 1'b1);
    score(1, "hold_run1", w0, 0);
    @(negedge clk);
    check("hold idle_gap_busy", 32'(busy_v[1]), 0);
    @(negedge clk);
    check("hold restart_busy", 32'(busy_v[1]), 1);
    start_v[1] = 1'b0;
    start_cyc  = cyc;
    push_exp(1, 25, ksa_model(img1, 1, 24'h9));
    w0 = wr_cnt[1];
    score(1, "hold_run2", w0, 0);
    post(1, "hold_run2", d0, 2);

    for (int i = 0; i < NI; i++) check($sformatf("protocol_violations%0d", i), viol[i], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
